// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream <-> FIFO bridge pair (axis2fifo / fifo2axis).
package axis_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/axis2fifo_frame_buf.sv
// Frame storage: DEPTH x DATA_WIDTH register array, one write port and a
// registered read port (rdata updates one clock after re, holds otherwise).
module frame_buf #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage itself is not reset; only the visible read register is.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis2fifo.sv
// AXI4-Stream slave that buffers one result frame, then hands it out through a
// simple pop-style read port.
//
// state    | meaning
// ST_IDLE  | waiting for start, tready low
// ST_RECV  | accepting beats into the buffer while room remains
// ST_FLUSH | buffer full, remaining beats of the frame are swallowed
// ST_DRAIN | frame complete, host pops words until empty
module axis2fifo
  import axis_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tvalid,
  output logic                  m_axis_tready,
  input  logic                  m_axis_tlast,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  frame_ready,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          dout_valid_q, dout_valid_d;
  logic          buf_we, buf_re;
  logic          tready, accept, pop;

  // tready comes only from registered state, never from tvalid.
  assign tready = ((state_q == ST_RECV) && (count_q < CW'(DEPTH))) || (state_q == ST_FLUSH);
  assign accept = m_axis_tvalid && tready;
  assign pop    = (state_q == ST_DRAIN) && read && (count_q != '0);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    dout_valid_d = 1'b0;
    buf_we       = 1'b0;
    buf_re       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RECV;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      ST_RECV: begin
        if (accept) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
          if (m_axis_tlast)                  state_d = ST_DRAIN;
          else if (count_q == CW'(DEPTH - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        overflow_d = 1'b1;
        if (accept && m_axis_tlast) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop) begin
          buf_re       = 1'b1;
          rd_ptr_d     = rd_ptr_q + AW'(1);
          count_d      = count_q - CW'(1);
          dout_valid_d = 1'b1;
          if (count_q == CW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_frame_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (m_axis_tdata),
    .re    (buf_re),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign m_axis_tready = tready;
  assign dout_valid    = dout_valid_q;
  assign frame_ready   = (state_q == ST_DRAIN);
  assign count         = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis2fifo.sv
// Directed bench for axis2fifo (DEPTH=4, DATA_WIDTH=32) with hand-computed expectations.
module tb_axis2fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] m_axis_tdata = '0;
  logic        m_axis_tvalid = 1'b0;
  logic        m_axis_tready;
  logic        m_axis_tlast = 1'b0;
  logic        read = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        frame_ready;
  logic [2:0]  count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  axis2fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .read          (read),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .frame_ready   (frame_ready),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    m_axis_tvalid = 1'b1;
    m_axis_tdata  = data;
    m_axis_tlast  = last;
    tick();
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk({tag, ".dv"}, 32'(dout_valid), 32'd1);
    chk({tag, ".dout"}, dout, exp);
  endtask

  initial begin
    // reset
    tick(); tick();
    rst = 1'b0;
    chk("rst.tready", 32'(m_axis_tready), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.dout", dout, 0);
    chk("rst.dv", 32'(dout_valid), 0);
    chk("rst.fr", 32'(frame_ready), 0);
    chk("rst.ovf", 32'(overflow), 0);

    // 1: full frame of exactly DEPTH beats
    do_start();
    chk("t1.tready_recv", 32'(m_axis_tready), 1);
    for (int i = 0; i < 4; i++) beat(32'hA0 + 32'(i), i == 3);
    chk("t1.count", 32'(count), 4);
    chk("t1.fr", 32'(frame_ready), 1);
    chk("t1.ovf", 32'(overflow), 0);
    chk("t1.tready_drain", 32'(m_axis_tready), 0);
    for (int i = 0; i < 4; i++) pop_check("t1.pop", 32'hA0 + 32'(i));
    chk("t1.fr_end", 32'(frame_ready), 0);
    chk("t1.count_end", 32'(count), 0);
    tick();
    chk("t1.dv_idle", 32'(dout_valid), 0);
    chk("t1.dout_hold", dout, 32'hA3);

    // 2: short frame, extra read ignored
    do_start();
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b1);
    chk("t2.count", 32'(count), 2);
    chk("t2.fr", 32'(frame_ready), 1);
    pop_check("t2.pop0", 32'h11);
    pop_check("t2.pop1", 32'h22);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("t2.extra_dv", 32'(dout_valid), 0);
    chk("t2.extra_dout", dout, 32'h22);
    chk("t2.count_end", 32'(count), 0);

    // 3: overlong frame, beats 5-6 dropped
    do_start();
    for (int i = 1; i <= 4; i++) beat(32'(i), 1'b0);
    chk("t3.flush_tready", 32'(m_axis_tready), 1);
    chk("t3.ovf_early", 32'(overflow), 0);
    beat(32'h5, 1'b0);
    chk("t3.ovf_set", 32'(overflow), 1);
    beat(32'h6, 1'b1);
    chk("t3.count", 32'(count), 4);
    chk("t3.ovf", 32'(overflow), 1);
    chk("t3.fr", 32'(frame_ready), 1);
    for (int i = 1; i <= 4; i++) pop_check("t3.pop", 32'(i));
    chk("t3.ovf_sticky", 32'(overflow), 1);

    // 4: start with tvalid in IDLE, then toggling tvalid
    m_axis_tvalid = 1'b1;
    m_axis_tdata  = 32'hEE;
    chk("t4.tready_idle", 32'(m_axis_tready), 0);
    do_start();
    chk("t4.no_accept_idle", 32'(count), 0);
    chk("t4.ovf_clr", 32'(overflow), 0);
    beat(32'hC0, 1'b0);
    m_axis_tdata = 32'hFF; tick();
    beat(32'hC1, 1'b0);
    m_axis_tdata = 32'hFF; tick();
    chk("t4.count_toggle", 32'(count), 2);
    beat(32'hC2, 1'b0);
    beat(32'hC3, 1'b1);
    m_axis_tvalid = 1'b1;
    chk("t4.tready_drain", 32'(m_axis_tready), 0);
    tick();
    m_axis_tvalid = 1'b0;
    chk("t4.count_drain", 32'(count), 4);
    for (int i = 0; i < 4; i++) pop_check("t4.pop", 32'hC0 + 32'(i));

    // 5: reset mid-frame
    do_start();
    beat(32'h55, 1'b0);
    beat(32'h66, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5.count", 32'(count), 0);
    chk("t5.tready", 32'(m_axis_tready), 0);
    chk("t5.dout", dout, 0);
    chk("t5.fr", 32'(frame_ready), 0);
    chk("t5.dv", 32'(dout_valid), 0);
    do_start();
    for (int i = 0; i < 4; i++) beat(32'hB0 + 32'(i), i == 3);
    chk("t5.count_new", 32'(count), 4);
    for (int i = 0; i < 4; i++) pop_check("t5.pop", 32'hB0 + 32'(i));

    // 6: start outside IDLE ignored
    do_start();
    beat(32'hD0, 1'b0);
    do_start();
    chk("t6.recv_count", 32'(count), 1);
    beat(32'hD1, 1'b1);
    do_start();
    chk("t6.drain_count", 32'(count), 2);
    chk("t6.drain_fr", 32'(frame_ready), 1);
    pop_check("t6.pop0", 32'hD0);
    pop_check("t6.pop1", 32'hD1);
    chk("t6.idle_fr", 32'(frame_ready), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
